// File: rtl/pipeline_fetch_ctrl_if.sv
// rtl/pipeline_fetch_ctrl_if.sv - fetch-control bundle between hazard unit/EX/imem and the fetch stage
//
// Purpose: carries the hold/bubble requests, branch redirect, instruction
// memory read data and the fetch-stage outputs as one bundle.
// Modports:
//   master - hazard unit / EX / instruction memory side (drives requests and Instruction_In)
//   slave  - pipeline_fetch_ctrl (drives PC, IF/ID, flush, watchdog and counters)
interface pipeline_fetch_ctrl_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  logic             PCWrite;
  logic             IFID_Write;
  logic             IDEX_mux_out;
  logic             branch_taken;
  logic [XLEN-1:0]  branch_target;
  logic [31:0]      Instruction_In;
  logic [XLEN-1:0]  PC_Out;
  logic [XLEN-1:0]  IFID_PC_Out;
  logic [31:0]      IFID_Instruction;
  logic             IDEX_Flush;
  logic             stall_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output PCWrite, IFID_Write, IDEX_mux_out, branch_taken, branch_target, Instruction_In,
    input  PC_Out, IFID_PC_Out, IFID_Instruction, IDEX_Flush, stall_timeout,
           stall_cycles, flush_count
  );

  modport slave (
    input  PCWrite, IFID_Write, IDEX_mux_out, branch_taken, branch_target, Instruction_In,
    output PC_Out, IFID_PC_Out, IFID_Instruction, IDEX_Flush, stall_timeout,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_fetch_ctrl.sv
// rtl/pipeline_fetch_ctrl.sv - PC and IF/ID owner applying load-use holds and branch redirects
//
// Purpose: owns the fetch PC and the IF/ID pipeline register of the 5-stage
// core. Applies hold requests from the hazard unit, redirects from EX, emits
// the ID/EX bubble select and watches for stalls that never release.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-low reset
//   bus   - pipeline_fetch_ctrl_if.slave (requests, redirect, imem data in;
//           PC_Out, IF/ID, IDEX_Flush, stall_timeout, perf counters out)
// Configuration macro: PIPE_PERF_CNT_EN enables the stall_cycles/flush_count
// counters; without it both read as zero and no counter flops exist.
module pipeline_fetch_ctrl #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
  parameter int              MAX_STALL = 8,
  parameter int              CNT_W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_fetch_ctrl_if.slave   bus
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_FLUSH
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  ifid_pc;
  logic [31:0]      ifid_instr;
  logic [RUN_W-1:0] stall_run;
  logic [RUN_W-1:0] stall_run_next;
  logic             timeout;
  logic             stall_req;

  // A redirect always wins over a hold request.
  assign stall_req = !bus.branch_taken && (!bus.PCWrite || !bus.IFID_Write);

  always_comb begin
    state_next = ST_RUN;
    if (bus.branch_taken) begin
      state_next = ST_FLUSH;
    end else if (!bus.PCWrite || !bus.IFID_Write) begin
      state_next = ST_STALL;
    end
  end

  // Coming from a non-stall cycle the run restarts at one; otherwise it
  // counts up and parks at MAX_STALL.
  always_comb begin
    stall_run_next = RUN_W'(1);
    if (state == ST_STALL) begin
      stall_run_next = (stall_run == RUN_MAX) ? stall_run : stall_run + RUN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_RUN;
      pc         <= RESET_PC;
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      stall_run  <= '0;
      timeout    <= 1'b0;
    end else begin
      state <= state_next;

      if (bus.branch_taken) begin
        pc         <= bus.branch_target;
        ifid_pc    <= pc;
        ifid_instr <= NOP_INSTR;
      end else begin
        if (bus.PCWrite) begin
          pc <= pc + XLEN'(4);
        end
        if (bus.IFID_Write) begin
          ifid_pc    <= pc;
          ifid_instr <= bus.Instruction_In;
        end
      end

      if (stall_req) begin
        stall_run <= stall_run_next;
        if (stall_run_next == RUN_MAX) begin
          timeout <= 1'b1;
        end
      end else begin
        stall_run <= '0;
      end
    end
  end

  assign bus.PC_Out           = pc;
  assign bus.IFID_PC_Out      = ifid_pc;
  assign bus.IFID_Instruction = ifid_instr;
  assign bus.IDEX_Flush       = bus.branch_taken | ~bus.IDEX_mux_out;
  assign bus.stall_timeout    = timeout;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_req && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (bus.branch_taken && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_count  = flush_cnt;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_fetch_ctrl.sv
// tb/tb_pipeline_fetch_ctrl.sv - scoreboard bench for pipeline_fetch_ctrl
module tb_pipeline_fetch_ctrl;
  localparam int XLEN      = 64;
  localparam int CNT_W     = 32;
  localparam int MAX_STALL = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_fetch_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  pipeline_fetch_ctrl #(
    .XLEN(XLEN), .RESET_PC('0), .NOP_INSTR(NOP), .MAX_STALL(MAX_STALL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [63:0] pc;
    logic [63:0] ifpc;
    logic [31:0] ins;
    logic        fl;
    logic        to;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 0;

  // Reference machine state, advanced once per clock.
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_ifins;
  int          m_run;
  logic        m_to;
  logic [31:0] m_sc, m_fc;

  function automatic logic [31:0] imem(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0003;
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endfunction

  task automatic model_reset();
    m_pc = '0; m_ifpc = '0; m_ifins = NOP; m_run = 0; m_to = 1'b0; m_sc = '0; m_fc = '0;
  endtask

  task automatic step(input logic rst, input logic pcw, input logic ifw, input logic mux,
                      input logic br, input logic [63:0] tgt);
    exp_t e;
    logic [31:0] ins;
    @(negedge clk);
    ins = imem(m_pc);
    reset = rst;
    bus.PCWrite = pcw; bus.IFID_Write = ifw; bus.IDEX_mux_out = mux;
    bus.branch_taken = br; bus.branch_target = tgt; bus.Instruction_In = ins;
    e.pc = m_pc; e.ifpc = m_ifpc; e.ins = m_ifins; e.fl = br | ~mux; e.to = m_to;
`ifdef PIPE_PERF_CNT_EN
    e.sc = m_sc; e.fc = m_fc;
`else
    e.sc = '0; e.fc = '0;
`endif
    expq.push_back(e);
    if (!rst) begin
      model_reset();
    end else begin
      if (br) begin
        m_ifpc = m_pc; m_ifins = NOP; m_pc = tgt; m_fc++;
      end else begin
        if (ifw) begin m_ifpc = m_pc; m_ifins = ins; end
        if (pcw) m_pc = m_pc + 64'd4;
      end
      if (!br && (!pcw || !ifw)) begin
        m_sc++;
        m_run = (m_run < MAX_STALL) ? m_run + 1 : MAX_STALL;
        if (m_run == MAX_STALL) m_to = 1'b1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 1, 1, 0, '0);
  endtask

  task automatic stall_n(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, '0);
  endtask

  // Monitor: checks the DUT against each queued expectation mid-cycle.
  initial begin : monitor
    int budget;
    exp_t e;
    budget = 0;
    while (!(done && expq.size() == 0) && budget < 20000) begin
      @(negedge clk);
      #2;
      budget++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("pc_out", bus.PC_Out, e.pc);
        chk("ifid_pc", bus.IFID_PC_Out, e.ifpc);
        chk("ifid_instr", 64'(bus.IFID_Instruction), 64'(e.ins));
        chk("idex_flush", 64'(bus.IDEX_Flush), 64'(e.fl));
        chk("stall_timeout", 64'(bus.stall_timeout), 64'(e.to));
        chk("stall_cycles", 64'(bus.stall_cycles), 64'(e.sc));
        chk("flush_count", 64'(bus.flush_count), 64'(e.fc));
      end
    end
    if (budget >= 20000) begin
      bad++;
      $display("FAIL monitor_budget actual=%0d required=<20000", budget);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : driver
    logic [63:0] tgt;
    int r;
    reset = 1'b0;
    bus.PCWrite = 1'b1; bus.IFID_Write = 1'b1; bus.IDEX_mux_out = 1'b1;
    bus.branch_taken = 1'b0; bus.branch_target = '0; bus.Instruction_In = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    // Reset state then straight-line fetch 0,4,8.
    step(0, 1, 1, 1, 0, '0);
    run_n(3);
    // Single-cycle hazard pulse at PC=8.
    stall_n(1);
    run_n(2);
    // Redirect overriding a stall request.
    step(1, 0, 1, 1, 1, 64'h100);
    run_n(3);
    // Watchdog boundary: 7 stalls must not trip it, 8 must, and it stays set.
    stall_n(MAX_STALL - 1);
    run_n(1);
    stall_n(MAX_STALL);
    run_n(3);
    // Wrap at the top of the address space.
    step(1, 1, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    run_n(3);
    // Reset clears the sticky timeout; then 3 stalls, 2 redirects, reset mid-stall.
    step(0, 1, 1, 1, 0, '0);
    stall_n(3);
    step(1, 1, 1, 1, 1, 64'h2000);
    step(1, 1, 1, 1, 1, 64'h3000);
    stall_n(1);
    step(0, 0, 0, 0, 0, '0);
    run_n(2);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      tgt = {$urandom, $urandom} & ~64'h3;
      if (r < 2)       step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), tgt);
      else if (r < 12) step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1, tgt);
      else if (r < 35) step(1, 1'($urandom), 1'($urandom), 1'($urandom), 0, tgt);
      else if (r < 45) stall_n($urandom_range(1, MAX_STALL + 2));
      else             step(1, 1, 1, 1'($urandom_range(0, 7) != 0), 0, tgt);
    end
    run_n(2);
    done = 1;
  end
endmodule
